luhn_msg_arbiter: RTL and testbench
===================================

Name: luhn_msg_arbiter

Overview:
- Shares one Luhn mod-16 checker engine between NUM_REQ independent requesters. Each requester has its own size/data/check valid-ready streams.
- Sits between the requester-facing stream ports and the single luhnmod16 engine instance.
- Grants one whole message at a time: size word, then exactly `size` nibbles, then one check result. The result is routed back to the owning requester.
- Arbitration is round-robin at message granularity.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SIZE_W, 8, width of the size word (nibble count).
- IDX_W, $clog2(NUM_REQ), width of the owner index and round-robin pointer.

Ports:
- clock  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- size_valid  in  NUM_REQ  per-requester size valid.
- size_ready  out  NUM_REQ  per-requester size ready.
- size  in  NUM_REQ*SIZE_W  per-requester size; requester i uses bits [i*SIZE_W +: SIZE_W].
- data_valid  in  NUM_REQ  per-requester nibble valid.
- data_ready  out  NUM_REQ  per-requester nibble ready.
- data  in  NUM_REQ*4  per-requester nibble; requester i uses bits [i*4 +: 4].
- check_valid  out  NUM_REQ  per-requester result valid.
- check_ready  in  NUM_REQ  per-requester result ready.
- check  out  NUM_REQ  per-requester result; 1 = message passes.
- m_size_valid  out  1  size valid to engine.
- m_size_ready  in  1  size ready from engine.
- m_size  out  SIZE_W  size to engine.
- m_data_valid  out  1  nibble valid to engine.
- m_data_ready  in  1  nibble ready from engine.
- m_data  out  4  nibble to engine.
- m_check_valid  in  1  result valid from engine.
- m_check_ready  out  1  result ready to engine.
- m_check  in  1  result from engine.

Behaviour:
- Handshake rule: a transfer occurs on a rising clock edge when valid and ready are both high. Valid, once raised, holds with stable payload until the transfer.
- Reset: every output is 0. State = IDLE, rr_ptr = 0, owner = 0, remaining count = 0, result register = 0.
- IDLE:
  - The winner is the first requester with size_valid=1, searching from rr_ptr upward with wrap. size_ready is 1 combinationally for the winner only.
  - On that transfer: owner <= winner, size_reg <= size of the winner.
  - Next state is ISSUE if the size is nonzero, else ZERO.
  - With no size_valid asserted, stay in IDLE.
- ZERO (size = 0):
  - The engine is not used.
  - Result register <= 1 (an empty message passes). Next state is RETURN.
- ISSUE:
  - m_size_valid=1, m_size=size_reg.
  - On m_size_ready: remaining <= size_reg, go to STREAM.
- STREAM: zero-latency combinational pass-through for the owner only.
  - m_data_valid=data_valid[owner], m_data=data of the owner, data_ready[owner]=m_data_ready.
  - data_ready of every non-owner is 0; their data_valid is ignored.
  - Each transfer decrements remaining. The transfer with remaining==1 moves to WAIT_RES.
- WAIT_RES:
  - m_check_ready=1. On m_check_valid: result register <= m_check, go to RETURN.
- RETURN:
  - check_valid[owner]=1, check[owner]=result register. All other check_valid and check bits are 0.
  - On check_ready[owner]: rr_ptr <= (owner+1) mod NUM_REQ, go to IDLE.
  - The next grant is evaluated in the IDLE cycle, so there is one bubble cycle between messages.
- Size ready outside IDLE: size_ready is 0 for every requester in all other states. A new size_valid from any requester, including the owner, waits.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that has just been served has the lowest priority next time, so no requester starves.
- Width rule: remaining is SIZE_W bits and never underflows, because it decrements only in STREAM while nonzero. The maximum message is 2^SIZE_W-1 nibbles.
- Engine rules:
  - m_check_valid arriving outside WAIT_RES is not accepted (m_check_ready=0 there).
  - The engine must emit exactly one result per size word.
- Reset mid-operation: the in-flight message is discarded with no result returned. The engine shares rst_n and is reset in the same cycle.

Optional Feature:
- Macro: LUHN_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index requester with size_valid=1. rr_ptr is not implemented; the port list is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Package luhn_arb_pkg holds:
  - state enum: IDLE, ISSUE, STREAM, WAIT_RES, RETURN, ZERO;
  - constant NIBBLE_W=4;
  - default SIZE_W=8.
- One sub-module: luhn_rr_pick. It is combinational: inputs req vector and ptr, outputs grant index and any_req. It holds the fixed-priority variant under the macro. The FSM, counter and steering stay in the top.

Test Plan:
- Single requester: req0 sends size=3 and nibbles 1,2,3; engine BFM returns check=1.
  - Engine sees m_size=3 and exactly 3 data transfers in order.
  - check_valid[0] rises with check[0]=1; req1 ports stay 0.
- Contention: req0 and req1 assert size_valid in the same cycle with rr_ptr=0.
  - req0 is served first, then req1.
  - Repeat with req1 re-requesting immediately: the grants alternate 0,1,0,1.
  - With LUHN_ARB_FIXED_PRIO_EN, req0 always wins.
- Backpressure: m_data_ready toggles 1,0,0,1 and data_valid[owner] drops mid-stream.
  - No nibble is lost or duplicated; the nibble count seen at the engine equals size.
  - check_ready[owner] is held 0 for 5 cycles; check_valid[owner] and check[owner] stay stable.
- Zero size: req1 sends size=0.
  - m_size_valid never rises; check_valid[1]=1 with check[1]=1 on the cycle after the size transfer.
- Reset mid-message: assert rst_n=0 after 2 of 5 nibbles.
  - All outputs are 0 the next cycle and no check_valid is produced.
  - After release, a fresh size=1 message from req1 completes normally.
- Non-owner isolation: during req0's STREAM, req1 holds data_valid=1 and size_valid=1.
  - data_ready[1] and size_ready[1] stay 0 until req0's RETURN completes.

Source files
------------

// File: rtl/luhn_arb_pkg.sv
// Shared state encoding and constants for the Luhn mod-16 message arbiter.
package luhn_arb_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int DEFAULT_SIZE_W = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        RETURN   = 3'd4,
        ZERO     = 3'd5
    } arb_state_e;

endpackage

// File: rtl/luhn_rr_pick.sv
// Combinational requester picker: round-robin from ptr, or lowest index when
// LUHN_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module luhn_rr_pick
    import luhn_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

`ifdef LUHN_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) grant = IDX_W'(i);
        end
    end
`else
    int idx;

    // Scan from the farthest offset down so the requester closest to ptr wins last.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[IDX_W'(idx)]) grant = IDX_W'(idx);
        end
    end
`endif

    assign any_req = |req;

endmodule

// File: rtl/luhn_msg_arbiter.sv
// Shares one Luhn mod-16 engine between NUM_REQ requesters, one whole message per grant.
// Define LUHN_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module luhn_msg_arbiter
    import luhn_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SIZE_W  = DEFAULT_SIZE_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           size_valid,
    output logic [NUM_REQ-1:0]           size_ready,
    input  logic [NUM_REQ*SIZE_W-1:0]    size,
    input  logic [NUM_REQ-1:0]           data_valid,
    output logic [NUM_REQ-1:0]           data_ready,
    input  logic [NUM_REQ*NIBBLE_W-1:0]  data,
    output logic [NUM_REQ-1:0]           check_valid,
    input  logic [NUM_REQ-1:0]           check_ready,
    output logic [NUM_REQ-1:0]           check,
    output logic                         m_size_valid,
    input  logic                         m_size_ready,
    output logic [SIZE_W-1:0]            m_size,
    output logic                         m_data_valid,
    input  logic                         m_data_ready,
    output logic [NIBBLE_W-1:0]          m_data,
    input  logic                         m_check_valid,
    output logic                         m_check_ready,
    input  logic                         m_check
);

    // Valid/ready: a beat transfers on a rising edge with valid and ready both high;
    // valid holds with stable payload until then. Ready never waits on a later valid.

    arb_state_e         state;
    logic [IDX_W-1:0]   owner;
    logic [SIZE_W-1:0]  size_reg;
    logic [SIZE_W-1:0]  remaining;
    logic               result;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [IDX_W-1:0]   pick_ptr;
    logic [SIZE_W-1:0]  win_size;

`ifdef LUHN_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0]   rr_ptr;
    assign pick_ptr = rr_ptr;
`endif

    luhn_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (size_valid),
        .ptr     (pick_ptr),
        .grant   (winner),
        .any_req (any_req)
    );

    assign win_size = size[int'(winner)*SIZE_W +: SIZE_W];

    // Steering is decoded from the registered state; data path is a zero-latency pass-through.
    always_comb begin
        size_ready    = '0;
        data_ready    = '0;
        check_valid   = '0;
        check         = '0;
        m_size_valid  = (state == ISSUE);
        m_size        = size_reg;
        m_data_valid  = 1'b0;
        m_data        = '0;
        m_check_ready = (state == WAIT_RES);
        case (state)
            IDLE: begin
                if (any_req && rst_n) size_ready[winner] = 1'b1;
            end
            STREAM: begin
                m_data_valid      = data_valid[owner];
                m_data            = data[int'(owner)*NIBBLE_W +: NIBBLE_W];
                data_ready[owner] = m_data_ready;
            end
            RETURN: begin
                check_valid[owner] = 1'b1;
                check[owner]       = result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            size_reg  <= '0;
            remaining <= '0;
            result    <= 1'b0;
`ifndef LUHN_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        size_reg <= win_size;
                        state    <= (win_size == '0) ? ZERO : ISSUE;
                    end
                end
                ZERO: begin
                    // An empty message passes without touching the engine.
                    result <= 1'b1;
                    state  <= RETURN;
                end
                ISSUE: begin
                    if (m_size_ready) begin
                        remaining <= size_reg;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (data_valid[owner] && m_data_ready) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == SIZE_W'(1)) state <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (m_check_valid) begin
                        result <= m_check;
                        state  <= RETURN;
                    end
                end
                RETURN: begin
                    if (check_ready[owner]) begin
`ifndef LUHN_ARB_FIXED_PRIO_EN
                        rr_ptr <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
`endif
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_luhn_msg_arbiter.sv
// Bench for luhn_msg_arbiter: requester drivers, an engine model with backpressure,
// and result/engine-side scoreboards. Expectations follow LUHN_ARB_FIXED_PRIO_EN.
module tb_luhn_msg_arbiter;

    localparam int NUM_REQ = 2;
    localparam int SIZE_W  = 8;
    localparam int TMO     = 200;

    logic                        clock = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_REQ-1:0]          size_valid = '0;
    logic [NUM_REQ-1:0]          size_ready;
    logic [NUM_REQ*SIZE_W-1:0]   size = '0;
    logic [NUM_REQ-1:0]          data_valid = '0;
    logic [NUM_REQ-1:0]          data_ready;
    logic [NUM_REQ*4-1:0]        data = '0;
    logic [NUM_REQ-1:0]          check_valid;
    logic [NUM_REQ-1:0]          check_ready = '0;
    logic [NUM_REQ-1:0]          check;
    logic                        m_size_valid;
    logic                        m_size_ready = 1'b0;
    logic [SIZE_W-1:0]           m_size;
    logic                        m_data_valid;
    logic                        m_data_ready = 1'b0;
    logic [3:0]                  m_data;
    logic                        m_check_valid = 1'b0;
    logic                        m_check_ready;
    logic                        m_check = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]        exp_q[$];       // {requester, check} in completion order
    logic [SIZE_W-1:0] exp_size_q[$];
    logic [3:0]        exp_nib_q[$];
    logic [0:0]        eng_res_q[$];

    logic [NUM_REQ-1:0] done = '0;
    logic               zero_phase = 1'b0;

    luhn_msg_arbiter #(.NUM_REQ(NUM_REQ), .SIZE_W(SIZE_W)) dut (
        .clock(clock), .rst_n(rst_n),
        .size_valid(size_valid), .size_ready(size_ready), .size(size),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .check_valid(check_valid), .check_ready(check_ready), .check(check),
        .m_size_valid(m_size_valid), .m_size_ready(m_size_ready), .m_size(m_size),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data(m_data),
        .m_check_valid(m_check_valid), .m_check_ready(m_check_ready), .m_check(m_check)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib(input int m, input int k);
        return 4'(m * 7 + k + 1);
    endfunction

    function automatic logic [22:0] all_outs();
        return {size_ready, data_ready, check_valid, check, m_size_valid, m_size,
                m_data_valid, m_data, m_check_ready};
    endfunction

    task automatic expect_msg(input int r, input int m, input int sz, input logic res);
        if (sz > 0) begin
            exp_size_q.push_back(SIZE_W'(sz));
            for (int k = 0; k < sz; k++) exp_nib_q.push_back(nib(m, k));
            eng_res_q.push_back(res);
        end
        exp_q.push_back({4'(r), res});
    endtask

    // ---------------- requester driver (called at a negedge, returns at a negedge) ----------------
    task automatic req_send(input int r, input int m, input int sz, input int n_send,
                            input int gap, input int hold, input bit pre, input logic res);
        int t;
        size_valid[r] = 1'b1;
        size[r*SIZE_W +: SIZE_W] = SIZE_W'(sz);
        if (pre) begin
            data_valid[r] = 1'b1;
            data[r*4 +: 4] = nib(m, 0);
        end
        t = 0;
        #3;
        while (!size_ready[r] && t < TMO) begin @(negedge clock); #3; t++; end
        check_eq("size_handshake", 32'(t < TMO), 1);
        @(posedge clock);
        @(negedge clock);
        size_valid[r] = 1'b0;
        for (int k = 0; k < n_send; k++) begin
            if (k == 1 && gap > 0) begin
                data_valid[r] = 1'b0;
                repeat (gap) @(negedge clock);
            end
            data_valid[r] = 1'b1;
            data[r*4 +: 4] = nib(m, k);
            t = 0;
            #3;
            while (!data_ready[r] && t < TMO) begin @(negedge clock); #3; t++; end
            check_eq("data_handshake", 32'(t < TMO), 1);
            @(posedge clock);
            @(negedge clock);
        end
        data_valid[r] = 1'b0;
        if (n_send == sz) begin
            t = 0;
            #3;
            while (!check_valid[r] && t < TMO) begin @(negedge clock); #3; t++; end
            check_eq("result_arrives", 32'(t < TMO), 1);
            for (int h = 0; h < hold; h++) begin
                check_eq("hold_valid", 32'(check_valid[r]), 1);
                check_eq("hold_check", 32'(check[r]), 32'(res));
                @(negedge clock);
                #3;
            end
            check_ready[r] = 1'b1;
            @(posedge clock);
            done[r] = 1'b1;
            @(negedge clock);
            check_ready[r] = 1'b0;
        end
    endtask

    // ---------------- engine model: data ready pattern 1,0,0,1 ----------------
    int         eng_st  = 0;
    int         eng_cnt = 0;
    int         bp_idx  = 0;
    logic       eng_res = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;

    always @(negedge clock) begin
        #2;
        if (!rst_n) begin
            eng_st = 0; eng_cnt = 0; bp_idx = 0;
            m_size_ready = 1'b0; m_data_ready = 1'b0; m_check_valid = 1'b0; m_check = 1'b0;
        end else begin
            case (eng_st)
                0: begin
                    m_size_ready = 1'b1; m_data_ready = 1'b0; m_check_valid = 1'b0;
                    if (m_size_valid) begin
                        check_eq("eng_size_expected", 32'(exp_size_q.size() > 0), 1);
                        if (exp_size_q.size() > 0) check_eq("eng_size", 32'(m_size), 32'(exp_size_q.pop_front()));
                        eng_cnt = int'(m_size);
                        bp_idx  = 0;
                        eng_st  = 1;
                    end
                end
                1: begin
                    m_size_ready = 1'b0;
                    m_data_ready = bp_pat[bp_idx];
                    bp_idx = (bp_idx + 1) % 4;
                    if (m_data_valid && m_data_ready) begin
                        check_eq("eng_nib_expected", 32'(exp_nib_q.size() > 0), 1);
                        if (exp_nib_q.size() > 0) check_eq("eng_nib", 32'(m_data), 32'(exp_nib_q.pop_front()));
                        eng_cnt--;
                        if (eng_cnt <= 0) begin
                            check_eq("eng_res_expected", 32'(eng_res_q.size() > 0), 1);
                            eng_res = (eng_res_q.size() > 0) ? eng_res_q.pop_front() : 1'b0;
                            eng_st  = 2;
                        end
                    end
                end
                default: begin
                    m_data_ready  = 1'b0;
                    m_check_valid = 1'b1;
                    m_check       = eng_res;
                    if (m_check_ready) eng_st = 0;
                end
            endcase
        end
    end

    // ---------------- result monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [4:0] e;
        #4;
        if (rst_n) begin
            check_eq("check_valid_onehot", 32'($countones(check_valid) <= 1), 1);
            check_eq("check_without_valid", 32'(check & ~check_valid), 0);
            check_eq("size_ready_onehot", 32'($countones(size_ready) <= 1), 1);
            check_eq("data_ready_onehot", 32'($countones(data_ready) <= 1), 1);
            if (zero_phase) check_eq("zero_m_size_valid", 32'(m_size_valid), 0);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (check_valid[r] && check_ready[r]) begin
                    check_eq("result_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("result_owner", 32'(r), 32'(e[4:1]));
                        check_eq("result_check", 32'(check[r]), 32'(e[0]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t, r, sz, m, gap, hold;
        logic res;

        repeat (3) @(negedge clock);
        #3;
        check_eq("reset_outputs", 32'(all_outs()), 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // Contention from rr_ptr=0, each requester re-requesting immediately.
`ifdef LUHN_ARB_FIXED_PRIO_EN
        expect_msg(0, 10, 2, 1); expect_msg(0, 12, 1, 1);
        expect_msg(1, 11, 3, 0); expect_msg(1, 13, 2, 0);
`else
        expect_msg(0, 10, 2, 1); expect_msg(1, 11, 3, 0);
        expect_msg(0, 12, 1, 1); expect_msg(1, 13, 2, 0);
`endif
        fork
            begin req_send(0, 10, 2, 2, 0, 0, 0, 1); req_send(0, 12, 1, 1, 0, 0, 0, 1); end
            begin req_send(1, 11, 3, 3, 0, 0, 0, 0); req_send(1, 13, 2, 2, 0, 0, 0, 0); end
        join

        // Single requester: nibbles 1,2,3, engine passes.
        expect_msg(0, 0, 3, 1);
        req_send(0, 0, 3, 3, 0, 0, 0, 1);

        // Backpressure: valid gap mid-stream, result held unaccepted for 5 cycles.
        expect_msg(1, 30, 6, 1);
        req_send(1, 30, 6, 6, 2, 5, 0, 1);

        // Zero-size message never reaches the engine and passes.
        zero_phase = 1'b1;
        expect_msg(1, 31, 0, 1);
        req_send(1, 31, 0, 0, 0, 0, 0, 1);
        zero_phase = 1'b0;

        // Non-owner isolation while req0 streams.
        done = '0;
        expect_msg(0, 40, 4, 1);
        expect_msg(1, 41, 2, 0);
        fork
            req_send(0, 40, 4, 4, 0, 0, 0, 1);
            begin @(negedge clock); @(negedge clock); req_send(1, 41, 2, 2, 0, 0, 1, 0); end
            begin
                @(negedge clock); @(negedge clock);
                t = 0;
                while (t < TMO) begin
                    #3;
                    if (done[0]) break;
                    check_eq("iso_size_ready1", 32'(size_ready[1]), 0);
                    check_eq("iso_data_ready1", 32'(data_ready[1]), 0);
                    @(negedge clock);
                    t++;
                end
                check_eq("iso_owner_done", 32'(t < TMO), 1);
            end
        join

        // Reset after 2 of 5 nibbles: nothing returned, then a fresh message works.
        exp_size_q.push_back(SIZE_W'(5));
        for (int k = 0; k < 2; k++) exp_nib_q.push_back(nib(50, k));
        req_send(0, 50, 5, 2, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clock);
        #3;
        check_eq("midreset_outputs", 32'(all_outs()), 0);
        @(negedge clock);
        #3;
        check_eq("midreset_outputs_hold", 32'(all_outs()), 0);
        @(negedge clock);
        rst_n = 1'b1;
        expect_msg(1, 51, 1, 1);
        req_send(1, 51, 1, 1, 0, 0, 0, 1);

        // Random sequential messages.
        for (int i = 0; i < 8; i++) begin
            r    = $urandom_range(0, 1);
            sz   = $urandom_range(0, 6);
            m    = $urandom_range(60, 200);
            gap  = $urandom_range(0, 2);
            hold = $urandom_range(0, 2);
            res  = (sz == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            expect_msg(r, m, sz, res);
            req_send(r, m, sz, sz, gap, hold, 0, res);
        end

        repeat (5) @(negedge clock);
        check_eq("exp_q_empty", 32'(exp_q.size()), 0);
        check_eq("exp_size_q_empty", 32'(exp_size_q.size()), 0);
        check_eq("exp_nib_q_empty", 32'(exp_nib_q.size()), 0);
        check_eq("eng_res_q_empty", 32'(eng_res_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
